// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch/jump resolution and an iterative shift-add multiplier.
// Optional macro EX_MUL_EARLY_EXIT_EN ends a multiply as soon as the remaining multiplier bits are zero.
module ex_stage #(
   parameter int XLEN      = 32,
   parameter int MUL_STEPS = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] read_data1_ex,
   input  logic [31:0] read_data2_ex,
   input  logic [31:0] pc_ex,
   input  logic [31:0] imm_ext_ex,
   input  logic [2:0]  alu_control_ex,
   input  logic        alu_src_ex,
   input  logic        branch_ex,
   input  logic        jump_ex,
   input  logic        mul_ex,
   input  logic [1:0]  forward_a_ex,
   input  logic [1:0]  forward_b_ex,
   input  logic [31:0] alu_result_mem,
   input  logic [31:0] result_w,
   output logic [31:0] alu_result_ex,
   output logic [31:0] write_data_ex,
   output logic [31:0] pc_target_ex,
   output logic        pc_src_ex,
   output logic        mul_stall_ex
);

   localparam int CW = $clog2(MUL_STEPS) + 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [XLEN-1:0] src_a;
   logic [XLEN-1:0] fwd_b;
   logic [XLEN-1:0] src_b;
   logic [XLEN-1:0] alu_out;
   logic            zero;

   logic [1:0]      state;
   logic [1:0]      state_next;
   logic [XLEN-1:0] acc;
   logic [XLEN-1:0] acc_next;
   logic [XLEN-1:0] mcand;
   logic [XLEN-1:0] mcand_next;
   logic [XLEN-1:0] mplier;
   logic [XLEN-1:0] mplier_next;
   logic [CW-1:0]   count;
   logic [CW-1:0]   count_next;
   logic            last_step;

   always_comb begin
      src_a = read_data1_ex;
      case (forward_a_ex)
         2'b01:   src_a = result_w;
         2'b10:   src_a = alu_result_mem;
         default: src_a = read_data1_ex;
      endcase
   end

   always_comb begin
      fwd_b = read_data2_ex;
      case (forward_b_ex)
         2'b01:   fwd_b = result_w;
         2'b10:   fwd_b = alu_result_mem;
         default: fwd_b = read_data2_ex;
      endcase
   end

   assign src_b         = alu_src_ex ? imm_ext_ex : fwd_b;
   assign write_data_ex = fwd_b;

   always_comb begin
      alu_out = '0;
      case (alu_control_ex)
         3'b000: alu_out = src_a + src_b;
         3'b001: alu_out = src_a - src_b;
         3'b010: alu_out = src_a & src_b;
         3'b011: alu_out = src_a | src_b;
         3'b100: alu_out = src_a ^ src_b;
         3'b101: alu_out = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
         3'b110: alu_out = src_a << src_b[4:0];
         default: alu_out = src_a >> src_b[4:0];
      endcase
   end

   // zero always reflects the ALU, even while a product is being presented
   assign zero         = (alu_out == '0);
   assign pc_target_ex = pc_ex + imm_ext_ex;
   assign pc_src_ex    = (branch_ex & zero) | jump_ex;

   assign alu_result_ex = (state == DONE) ? acc : alu_out;
   assign mul_stall_ex  = reset & (((state == IDLE) & mul_ex) | (state == BUSY));

`ifdef EX_MUL_EARLY_EXIT_EN
   assign last_step = (count == CW'(MUL_STEPS - 1)) | (mplier[XLEN-1:1] == '0);
`else
   assign last_step = (count == CW'(MUL_STEPS - 1));
`endif

   // Operands are latched only on entry to BUSY; forwarded sources drift while EX/MEM is bubbled
   always_comb begin
      state_next  = state;
      acc_next    = acc;
      mcand_next  = mcand;
      mplier_next = mplier;
      count_next  = count;
      case (state)
         IDLE: begin
            if (mul_ex) begin
               state_next  = BUSY;
               acc_next    = '0;
               mcand_next  = src_a;
               mplier_next = fwd_b;
               count_next  = '0;
            end
         end
         BUSY: begin
            if (mplier[0]) begin
               acc_next = acc + mcand;
            end
            mcand_next  = {mcand[XLEN-2:0], 1'b0};
            mplier_next = {1'b0, mplier[XLEN-1:1]};
            count_next  = count + 1'b1;
            if (last_step) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         count  <= '0;
      end else begin
         state  <= state_next;
         acc    <= acc_next;
         mcand  <= mcand_next;
         mplier <= mplier_next;
         count  <= count_next;
      end
   end

endmodule
